parity_frame_gen: RTL and testbench
===================================

PARITY_FRAME_GEN -- requirements
Module: parity_frame_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 2..64.
REQ-002 SHALL have parameter MAX_WORDS, default 16: maximum words folded per frame, legal range 2..256; CW = $clog2(MAX_WORDS+1).
REQ-003 SHALL have ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- odd_mode  input  1  parity mode: 1 = odd, 0 = even; sampled only on the first accepted word of a frame.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  data word.
- in_last  input  1  final word of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_parity  output  1  frame parity bit.
- out_count  output  CW  words folded into out_parity.
- out_err  output  1  frame overflowed MAX_WORDS.

Function
REQ-004 SHALL transfer an input word only on a rising edge where in_valid=1 and in_ready=1.
REQ-005 SHALL transfer the result only on a rising edge where out_valid=1 and out_ready=1.
REQ-006 SHALL implement FSM states IDLE, ACCUM, DRAIN and DONE.
REQ-007 IDLE: in_ready=1, out_valid=0; on accept, acc = ^in_data, count = 1, mode latched from odd_mode; go to DONE if in_last, else go to ACCUM.
REQ-008 ACCUM: in_ready=1; on accept, acc ^= ^in_data and count += 1.
REQ-009 ACCUM exits: to DONE if in_last; else to DRAIN with err set if the new count equals MAX_WORDS; else stay in ACCUM.
REQ-010 DRAIN: in_ready=1; accepted words are discarded (acc and count unchanged); on an accepted word with in_last, go to DONE.
REQ-011 DONE: in_ready=0, out_valid=1; out_parity = acc XOR mode, out_count = count, out_err = err.
REQ-012 DONE: all outputs SHALL be held stable until the result is accepted; on accept go to IDLE, clear acc, count and err.
REQ-013 out_valid SHALL rise on the first edge after the in_last transfer (latency 1 cycle); the earliest next input accept is the cycle after the result transfer.
REQ-014 A word with in_last accepted exactly when count reaches MAX_WORDS SHALL go to DONE with out_err=0.
REQ-015 A single-word frame (in_last on the first word) SHALL be legal and give out_count=1.
REQ-016 Changes on odd_mode after the first word of a frame SHALL have no effect on that frame.
REQ-017 in_valid, in_data and in_last SHALL be ignored while in_ready=0.
REQ-018 out_parity, out_count and out_err SHALL read 0 whenever out_valid=0.

Reset
REQ-019 rst_n=0 at a rising edge SHALL force IDLE, acc=0, count=0, err=0 and mode=0, overriding any handshake in that cycle.
REQ-020 After reset: in_ready=1, out_valid=0, out_parity=0, out_count=0, out_err=0.
REQ-021 Reset mid-frame or in DONE SHALL discard the partial or pending result; no result is emitted for that frame.

Structure
REQ-022 Package parity_pkg SHALL hold the FSM state enum (IDLE, ACCUM, DRAIN, DONE) and the constants MODE_EVEN=0 and MODE_ODD=1.
REQ-023 Word parity SHALL come from sub-module xor_reduce_nand, parameter WIDTH: a combinational XOR tree built only from 4-NAND XOR cells via generate.
REQ-024 parity_frame_gen SHALL contain all registers; xor_reduce_nand SHALL contain none.

Verification (WIDTH=8, MAX_WORDS=4)
REQ-025 Single word: 0x01 with in_last, even mode -> next cycle out_valid=1, out_parity=1, out_count=1, out_err=0.
REQ-026 Odd mode: frame 0x03, 0xFF, 0x80(last) -> acc=1, out_parity=0, out_count=3, out_err=0; odd_mode toggled after word 1 has no effect.
REQ-027 Overflow: six words of 0x01, in_last on the 6th, even mode -> words 5 and 6 accepted and dropped; out_count=4, out_parity=0, out_err=1.
REQ-028 Exact fill: four words of 0x01, in_last on the 4th -> out_count=4, out_err=0.
REQ-029 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; after release, IDLE and in_ready=1 on the next cycle.
REQ-030 Reset mid-frame: rst_n=0 for one cycle after two words -> all outputs 0, no result emitted; the next frame 0x07(last) in even mode gives out_parity=1, out_count=1.

Source files
------------

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared FSM state and parity mode constants for parity_frame_gen
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/xor_reduce_nand.sv
// rtl/xor_reduce_nand.sv - combinational XOR reduction tree built from 4-NAND XOR cells
module xor_reduce_nand #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

  // Level l holds ceil(WIDTH / 2^l) nodes; odd leftovers pass straight up a level.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = (WIDTH + (1 << l) - 1) >> l;
    logic [N-1:0] v;

    if (l == 0) begin : g_leaf
      assign v = data;
    end else begin : g_inner
      localparam int NP = (WIDTH + (1 << (l - 1)) - 1) >> (l - 1);
      for (genvar j = 0; j < N; j++) begin : g_node
        if (2 * j + 1 < NP) begin : g_cell
          logic a, b, n1, n2, n3;
          assign a  = g_lvl[l-1].v[2*j];
          assign b  = g_lvl[l-1].v[2*j+1];
          assign n1 = ~(a & b);
          assign n2 = ~(a & n1);
          assign n3 = ~(b & n1);
          assign v[j] = ~(n2 & n3);
        end else begin : g_pass
          assign v[j] = g_lvl[l-1].v[2*j];
        end
      end
    end
  end

  assign parity = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/parity_frame_gen.sv
// rtl/parity_frame_gen.sv - folds word parities across a framed stream and emits one result per frame
module parity_frame_gen
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  parameter int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             odd_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_err
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  state_t          state, state_nxt;
  logic            acc, acc_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            err, err_nxt;
  logic            mode, mode_nxt;
  logic            word_par;
  logic            accept;
  logic [CW-1:0]   count_inc;

  xor_reduce_nand #(.WIDTH(WIDTH)) u_xor (
    .data   (in_data),
    .parity (word_par)
  );

  assign in_ready   = (state != DONE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign count_inc  = count + CW'(1);
  // Result fields are forced low outside DONE so idle outputs never leak stale state.
  assign out_parity = out_valid ? (acc ^ mode) : 1'b0;
  assign out_count  = out_valid ? count : '0;
  assign out_err    = out_valid ? err : 1'b0;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    err_nxt   = err;
    mode_nxt  = mode;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = word_par;
          count_nxt = CW'(1);
          mode_nxt  = odd_mode;
          state_nxt = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt   = acc ^ word_par;
          count_nxt = count_inc;
          if (in_last) begin
            state_nxt = DONE;
          end else if (count_inc == MAX_CNT) begin
            state_nxt = DRAIN;
            err_nxt   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && in_last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = 1'b0;
          count_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= 1'b0;
      count <= '0;
      err   <= 1'b0;
      mode  <= MODE_EVEN;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      err   <= err_nxt;
      mode  <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_parity_frame_gen.sv
// tb/tb_parity_frame_gen.sv - directed self-checking bench for parity_frame_gen
module tb_parity_frame_gen;

  localparam int WIDTH     = 8;
  localparam int MAX_WORDS = 4;
  localparam int CW        = $clog2(MAX_WORDS + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             odd_mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic [CW-1:0]    out_count;
  logic             out_err;

  int checks = 0;
  int errors = 0;

  parity_frame_gen #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .odd_mode   (odd_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .out_count  (out_count),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [WIDTH-1:0] d, input logic last);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic result(input string tag, input logic par, input int cnt, input logic er);
    check({tag, "_valid"},  32'(out_valid),  32'd1);
    check({tag, "_parity"}, 32'(out_parity), 32'(par));
    check({tag, "_count"},  32'(out_count),  32'(cnt));
    check({tag, "_err"},    32'(out_err),    32'(er));
    check({tag, "_nready"}, 32'(in_ready),   32'd0);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"},  32'(out_valid),  32'd0);
    check({tag, "_post_ready"},  32'(in_ready),   32'd1);
    check({tag, "_post_parity"}, 32'(out_parity), 32'd0);
    check({tag, "_post_count"},  32'(out_count),  32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    odd_mode  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready",  32'(in_ready),   32'd1);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_parity",    32'(out_parity), 32'd0);
    check("rst_count",     32'(out_count),  32'd0);
    check("rst_err",       32'(out_err),    32'd0);

    // single word, even mode
    send("single", 8'h01, 1'b1);
    result("single", 1'b1, 1, 1'b0);
    take("single");

    // odd mode latched on first word, toggled afterwards
    odd_mode = 1'b1;
    send("odd_w1", 8'h03, 1'b0);
    odd_mode = 1'b0;
    send("odd_w2", 8'hFF, 1'b0);
    send("odd_w3", 8'h80, 1'b1);
    result("odd", 1'b0, 3, 1'b0);
    take("odd");

    // overflow: words 5 and 6 dropped
    for (int i = 1; i <= 6; i++) begin
      send("ovf_w", 8'h01, i == 6);
      if (i == 5) check("ovf_drain_nvalid", 32'(out_valid), 32'd0);
    end
    result("ovf", 1'b0, 4, 1'b1);
    take("ovf");

    // exact fill
    for (int i = 1; i <= 4; i++) send("fill_w", 8'h01, i == 4);
    result("fill", 1'b0, 4, 1'b0);
    take("fill");

    // backpressure with ignored input activity
    send("bp_w", 8'h07, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      in_last  = 1'b1;
      odd_mode = 1'b1;
      tick();
      result("bp_hold", 1'b1, 1, 1'b0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    odd_mode = 1'b0;
    take("bp");

    // reset mid-frame discards partial result
    send("rstm_w1", 8'h01, 1'b0);
    send("rstm_w2", 8'h01, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstm_valid",  32'(out_valid),  32'd0);
    check("rstm_ready",  32'(in_ready),   32'd1);
    check("rstm_parity", 32'(out_parity), 32'd0);
    check("rstm_count",  32'(out_count),  32'd0);
    check("rstm_err",    32'(out_err),    32'd0);
    tick();
    check("rstm_no_result", 32'(out_valid), 32'd0);
    send("rstm_next", 8'h07, 1'b1);
    result("rstm_next", 1'b1, 1, 1'b0);
    take("rstm_next");

    // reset while a result is pending
    send("rstd_w", 8'h01, 1'b1);
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b0;
    rst_n     = 1'b1;
    out_ready = 1'b0;
    check("rstd_valid", 32'(out_valid), 32'd0);
    check("rstd_ready", 32'(in_ready),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
